// File: rtl/buzzer_scheduler.sv
// buzzer_scheduler: shares the single buzzer tone generator between three
// note requesters (0 = alarm melody, 1 = hourly chime, 2 = key-click beep).
// Requester 0 has the highest priority.
// A granted note drives the tone divider's half-period input for its duration.
// A silent gap follows, and then the block re-arbitrates.
// Optional feature macro: BUZZER_SCHED_PREEMPT_EN. When it is defined, a
// higher-priority request aborts the current note or gap. When it is not
// defined, every granted note plays to completion and is followed by its gap.

module buzzer_scheduler #(
    parameter int TICK_CYCLES = 100000,
    parameter int DUR_W       = 12,
    parameter int GAP_MS      = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [2:0]        req,
    input  logic [19:0]       req_period0,
    input  logic [19:0]       req_period1,
    input  logic [19:0]       req_period2,
    input  logic [DUR_W-1:0]  req_dur0,
    input  logic [DUR_W-1:0]  req_dur1,
    input  logic [DUR_W-1:0]  req_dur2,
    output logic [2:0]        ack,
    output logic [2:0]        done,
    output logic [2:0]        preempt,
    output logic [19:0]       period,
    output logic              tone_on,
    output logic              busy,
    output logic [1:0]        owner
);

    localparam int TICK_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int GAP_W    = (GAP_MS > 1) ? $clog2(GAP_MS + 1) : 1;
    localparam int MS_W     = (DUR_W > GAP_W) ? DUR_W : GAP_W;
    localparam int GAP_LAST = (GAP_MS > 0) ? GAP_MS - 1 : 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]        state;
    logic [TICK_W-1:0] tick_cnt;
    logic [MS_W-1:0]   ms_cnt;
    logic [MS_W-1:0]   dur_q;
    logic [1:0]        cur_idx;

    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic [19:0]       sel_period;
    logic [DUR_W-1:0]  sel_dur;
    logic              preempt_hit;
    logic              do_grant;
    logic              tick_last;
    logic              note_last;
    logic              gap_last;

    // Fixed-priority pick of the lowest requesting index and its note fields
    always_comb begin
        grant_valid = 1'b1;
        grant_idx   = 2'd0;
        sel_period  = req_period0;
        sel_dur     = req_dur0;
        if (req[0]) begin
            grant_idx  = 2'd0;
            sel_period = req_period0;
            sel_dur    = req_dur0;
        end else if (req[1]) begin
            grant_idx  = 2'd1;
            sel_period = req_period1;
            sel_dur    = req_dur1;
        end else if (req[2]) begin
            grant_idx  = 2'd2;
            sel_period = req_period2;
            sel_dur    = req_dur2;
        end else begin
            grant_valid = 1'b0;
        end
    end

`ifdef BUZZER_SCHED_PREEMPT_EN
    assign preempt_hit = grant_valid && (grant_idx < cur_idx);
`else
    assign preempt_hit = 1'b0;
`endif

    assign tick_last = (tick_cnt == TICK_W'(TICK_CYCLES - 1));
    assign note_last = tick_last && (ms_cnt == dur_q - 1'b1);
    assign gap_last  = tick_last && (ms_cnt == MS_W'(GAP_LAST));

    // Decide whether this cycle starts a new note (normal grant or preemption)
    always_comb begin
        do_grant = 1'b0;
        case (state)
            S_IDLE:  do_grant = grant_valid;
            S_PLAY:  do_grant = preempt_hit && !note_last;
            S_GAP:   do_grant = preempt_hit;
            default: do_grant = 1'b0;
        endcase
    end

    // Main sequencer: arbitration, note and gap timing, registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            ms_cnt   <= '0;
            dur_q    <= '0;
            cur_idx  <= 2'd3;
            ack      <= 3'b000;
            done     <= 3'b000;
            preempt  <= 3'b000;
            period   <= 20'd0;
            tone_on  <= 1'b0;
            busy     <= 1'b0;
            owner    <= 2'd3;
        end else begin
            ack     <= 3'b000;
            done    <= 3'b000;
            preempt <= 3'b000;
            if (!en) begin
                state    <= S_IDLE;
                tick_cnt <= '0;
                ms_cnt   <= '0;
                period   <= 20'd0;
                tone_on  <= 1'b0;
                busy     <= 1'b0;
                owner    <= 2'd3;
            end else if (do_grant) begin
`ifdef BUZZER_SCHED_PREEMPT_EN
                if (state == S_PLAY) begin
                    preempt <= 3'b001 << cur_idx;
                end
`endif
                state    <= S_PLAY;
                tick_cnt <= '0;
                ms_cnt   <= '0;
                dur_q    <= (sel_dur == '0) ? MS_W'(1) : MS_W'(sel_dur);
                cur_idx  <= grant_idx;
                ack      <= 3'b001 << grant_idx;
                period   <= sel_period;
                tone_on  <= (sel_period != 20'd0);
                busy     <= 1'b1;
                owner    <= grant_idx;
            end else if (state == S_PLAY && note_last) begin
                done     <= 3'b001 << cur_idx;
                tick_cnt <= '0;
                ms_cnt   <= '0;
                period   <= 20'd0;
                tone_on  <= 1'b0;
                owner    <= 2'd3;
                if (GAP_MS == 0) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end else begin
                    state <= S_GAP;
                end
            end else if (state == S_GAP && gap_last) begin
                state    <= S_IDLE;
                tick_cnt <= '0;
                ms_cnt   <= '0;
                busy     <= 1'b0;
            end else if (state == S_PLAY || state == S_GAP) begin
                tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
                if (tick_last && ms_cnt != {MS_W{1'b1}}) begin
                    ms_cnt <= ms_cnt + 1'b1;
                end
            end else if (state != S_IDLE) begin
                state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_buzzer_scheduler.sv
// tb_buzzer_scheduler: scoreboard bench for buzzer_scheduler with
// TICK_CYCLES=10 and GAP_MS=2, so one ms is 10 cycles and the gap is 20 cycles.

module tb_buzzer_scheduler;

    localparam int TICK = 10;
    localparam int GAPC = 20;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [2:0]  req;
    logic [19:0] req_period0, req_period1, req_period2;
    logic [11:0] req_dur0, req_dur1, req_dur2;
    logic [2:0]  ack, done, preempt;
    logic [19:0] period;
    logic        tone_on;
    logic        busy;
    logic [1:0]  owner;

    typedef struct {
        int          cyc;
        logic [2:0]  ack;
        logic [2:0]  done;
        logic [2:0]  pre;
        logic [19:0] period;
        logic [1:0]  owner;
        logic        busy;
    } ev_t;

    ev_t sb[$];
    ev_t exp_ev;
    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;

    buzzer_scheduler #(
        .TICK_CYCLES(TICK),
        .DUR_W(12),
        .GAP_MS(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .req(req),
        .req_period0(req_period0),
        .req_period1(req_period1),
        .req_period2(req_period2),
        .req_dur0(req_dur0),
        .req_dur1(req_dur1),
        .req_dur2(req_dur2),
        .ack(ack),
        .done(done),
        .preempt(preempt),
        .period(period),
        .tone_on(tone_on),
        .busy(busy),
        .owner(owner)
    );

    // Free-running clock and a cycle count advanced on every active edge
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Every pulse the DUT emits must match the oldest expected event
    always @(negedge clk) begin
        if ((ack | done | preempt) != 3'b000) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_pulse cyc=%0d ack=%b done=%b preempt=%b, none expected",
                         cyc, ack, done, preempt);
            end else begin
                exp_ev = sb.pop_front();
                if (cyc !== exp_ev.cyc || ack !== exp_ev.ack || done !== exp_ev.done ||
                    preempt !== exp_ev.pre || period !== exp_ev.period ||
                    owner !== exp_ev.owner || busy !== exp_ev.busy) begin
                    miscompares++;
                    $display("[TB] FAIL event got cyc=%0d ack=%b done=%b pre=%b period=%0d owner=%0d busy=%b want cyc=%0d ack=%b done=%b pre=%b period=%0d owner=%0d busy=%b",
                             cyc, ack, done, preempt, period, owner, busy,
                             exp_ev.cyc, exp_ev.ack, exp_ev.done, exp_ev.pre,
                             exp_ev.period, exp_ev.owner, exp_ev.busy);
                end
            end
        end
    end

    task automatic push_ev(input int c, input logic [2:0] a, input logic [2:0] d,
                           input logic [2:0] p, input logic [19:0] per,
                           input logic [1:0] own, input logic bsy);
        ev_t e;
        e.cyc = c; e.ack = a; e.done = d; e.pre = p;
        e.period = per; e.owner = own; e.busy = bsy;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        req = 3'b000;
        req_period0 = '0; req_period1 = '0; req_period2 = '0;
        req_dur0 = '0; req_dur1 = '0; req_dur2 = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (period !== 20'd0 || tone_on !== 1'b0 || busy !== 1'b0 || owner !== 2'd3 ||
            ack !== 3'b000 || done !== 3'b000 || preempt !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_values got period=%0d tone=%b busy=%b owner=%0d ack=%b done=%b pre=%b want 0 0 0 3 000 000 000",
                     period, tone_on, busy, owner, ack, done, preempt);
        end
        rst_n = 1'b1;
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_note();
        int c0;
        c0 = cyc;
        req_period2 = 20'd20000;
        req_dur2 = 12'd3;
        req = 3'b100;
        push_ev(c0 + 1, 3'b100, 3'b000, 3'b000, 20'd20000, 2'd2, 1'b1);
        push_ev(c0 + 1 + 3*TICK, 3'b000, 3'b100, 3'b000, 20'd0, 2'd3, 1'b1);
        wait_cyc(c0 + 1);
        req = 3'b000;
        wait_cyc(c0 + 16);
        vectors++;
        if (period !== 20'd20000 || tone_on !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_mid got period=%0d tone=%b want 20000 1", period, tone_on);
        end
        wait_cyc(c0 + 3*TICK);
        vectors++;
        if (period !== 20'd20000) begin
            miscompares++;
            $display("[TB] FAIL single_last_cycle got period=%0d want 20000", period);
        end
        wait_cyc(c0 + 3*TICK + GAPC);
        vectors++;
        if (busy !== 1'b1 || period !== 20'd0) begin
            miscompares++;
            $display("[TB] FAIL single_gap_end got busy=%b period=%0d want 1 0", busy, period);
        end
        wait_cyc(c0 + 1 + 3*TICK + GAPC);
        vectors++;
        if (busy !== 1'b0 || owner !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL single_idle got busy=%b owner=%0d want 0 3", busy, owner);
        end
        wait_cyc(c0 + 3*TICK + GAPC + 4);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL single_drain got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_priority();
        int c0;
        c0 = cyc;
        req_period0 = 20'd100; req_dur0 = 12'd1;
        req_period1 = 20'd200; req_dur1 = 12'd2;
        req_period2 = 20'd300; req_dur2 = 12'd1;
        req = 3'b111;
        push_ev(c0 + 1,  3'b001, 3'b000, 3'b000, 20'd100, 2'd0, 1'b1);
        push_ev(c0 + 11, 3'b000, 3'b001, 3'b000, 20'd0,   2'd3, 1'b1);
        push_ev(c0 + 32, 3'b010, 3'b000, 3'b000, 20'd200, 2'd1, 1'b1);
        push_ev(c0 + 52, 3'b000, 3'b010, 3'b000, 20'd0,   2'd3, 1'b1);
        push_ev(c0 + 73, 3'b100, 3'b000, 3'b000, 20'd300, 2'd2, 1'b1);
        push_ev(c0 + 83, 3'b000, 3'b100, 3'b000, 20'd0,   2'd3, 1'b1);
        wait_cyc(c0 + 1);
        req = 3'b110;
        wait_cyc(c0 + 31);
        vectors++;
        if (busy !== 1'b0 || owner !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL prio_idle_between got busy=%b owner=%0d want 0 3", busy, owner);
        end
        wait_cyc(c0 + 32);
        req = 3'b100;
        wait_cyc(c0 + 73);
        req = 3'b000;
        wait_cyc(c0 + 106);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL prio_drain got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_preempt();
        int c0;
        c0 = cyc;
        req_period1 = 20'd500; req_dur1 = 12'd3;
        req_period0 = 20'd700; req_dur0 = 12'd1;
        req = 3'b010;
        push_ev(c0 + 1, 3'b010, 3'b000, 3'b000, 20'd500, 2'd1, 1'b1);
`ifdef BUZZER_SCHED_PREEMPT_EN
        push_ev(c0 + 13, 3'b001, 3'b000, 3'b010, 20'd700, 2'd0, 1'b1);
        push_ev(c0 + 23, 3'b000, 3'b001, 3'b000, 20'd0,   2'd3, 1'b1);
`else
        push_ev(c0 + 31, 3'b000, 3'b010, 3'b000, 20'd0,   2'd3, 1'b1);
        push_ev(c0 + 52, 3'b001, 3'b000, 3'b000, 20'd700, 2'd0, 1'b1);
        push_ev(c0 + 62, 3'b000, 3'b001, 3'b000, 20'd0,   2'd3, 1'b1);
`endif
        wait_cyc(c0 + 1);
        req = 3'b000;
        wait_cyc(c0 + 12);
        req = 3'b001;
`ifdef BUZZER_SCHED_PREEMPT_EN
        wait_cyc(c0 + 13);
        req = 3'b000;
        wait_cyc(c0 + 46);
`else
        wait_cyc(c0 + 30);
        vectors++;
        if (period !== 20'd500 || owner !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL nopre_chime_kept got period=%0d owner=%0d want 500 1", period, owner);
        end
        wait_cyc(c0 + 52);
        req = 3'b000;
        wait_cyc(c0 + 85);
`endif
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL preempt_drain got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_en_drop();
        int c0;
        c0 = cyc;
        req_period0 = 20'd900; req_dur0 = 12'd2;
        req = 3'b001;
        push_ev(c0 + 1,  3'b001, 3'b000, 3'b000, 20'd900, 2'd0, 1'b1);
        push_ev(c0 + 9,  3'b001, 3'b000, 3'b000, 20'd900, 2'd0, 1'b1);
        push_ev(c0 + 29, 3'b000, 3'b001, 3'b000, 20'd0,   2'd3, 1'b1);
        wait_cyc(c0 + 5);
        en = 1'b0;
        wait_cyc(c0 + 6);
        vectors++;
        if (period !== 20'd0 || tone_on !== 1'b0 || busy !== 1'b0 || owner !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL en_off got period=%0d tone=%b busy=%b owner=%0d want 0 0 0 3",
                     period, tone_on, busy, owner);
        end
        wait_cyc(c0 + 8);
        en = 1'b1;
        wait_cyc(c0 + 9);
        req = 3'b000;
        wait_cyc(c0 + 28);
        vectors++;
        if (period !== 20'd900) begin
            miscompares++;
            $display("[TB] FAIL en_replay_full got period=%0d want 900", period);
        end
        wait_cyc(c0 + 51);
        vectors++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL en_drain got pending=%0d busy=%b want 0 0", sb.size(), busy);
            sb.delete();
        end
    endtask

    task automatic test_rest();
        int c0;
        c0 = cyc;
        req_period0 = 20'd0; req_dur0 = 12'd0;
        req = 3'b001;
        push_ev(c0 + 1,  3'b001, 3'b000, 3'b000, 20'd0, 2'd0, 1'b1);
        push_ev(c0 + 11, 3'b000, 3'b001, 3'b000, 20'd0, 2'd3, 1'b1);
        wait_cyc(c0 + 1);
        req = 3'b000;
        wait_cyc(c0 + 5);
        vectors++;
        if (tone_on !== 1'b0 || busy !== 1'b1 || owner !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL rest_state got tone=%b busy=%b owner=%0d want 0 1 0", tone_on, busy, owner);
        end
        wait_cyc(c0 + 33);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL rest_drain got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_async_reset();
        int c0;
        c0 = cyc;
        req_period2 = 20'd1234; req_dur2 = 12'd3;
        req = 3'b100;
        push_ev(c0 + 1, 3'b100, 3'b000, 3'b000, 20'd1234, 2'd2, 1'b1);
        wait_cyc(c0 + 1);
        req = 3'b000;
        wait_cyc(c0 + 10);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (period !== 20'd0 || tone_on !== 1'b0 || busy !== 1'b0 || owner !== 2'd3 ||
            ack !== 3'b000 || done !== 3'b000 || preempt !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL async_reset got period=%0d tone=%b busy=%b owner=%0d ack=%b done=%b pre=%b want 0 0 0 3 000 000 000",
                     period, tone_on, busy, owner, ack, done, preempt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(c0 + 40);
        vectors++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_drain got pending=%0d busy=%b want 0 0", sb.size(), busy);
            sb.delete();
        end
    endtask

    // Scenario sequence, then the one summary line
    initial begin
        test_reset();
        test_single_note();
        test_priority();
        test_preempt();
        test_en_drop();
        test_rest();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
